// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch control FSM (T0, T1, T2, optional T3, EXEC) with a completed-fetch counter.
// Define FETCH_INDIRECT_EN to add the indirect-address cycle T3; the default build goes straight from T2 to EXEC.
module fetch_sequencer #(
  parameter int IR_W = 16
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            start,
  input  logic            halt,
  input  logic            exec_done,
  input  logic [IR_W-1:0] ir_in,
  output logic            pc_read,
  output logic            pc_inc,
  output logic            ar_load,
  output logic            mem_read,
  output logic            ir_load,
  output logic            exec_start,
  output logic [2:0]      opcode,
  output logic            indirect,
  output logic            busy,
  output logic [7:0]      fetch_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_T0     = 3'd1;
  localparam logic [2:0] S_T1     = 3'd2;
  localparam logic [2:0] S_T2     = 3'd3;
`ifdef FETCH_INDIRECT_EN
  localparam logic [2:0] S_T3     = 3'd4;
`endif
  localparam logic [2:0] S_EXEC   = 3'd5;
  localparam logic [2:0] S_HALTED = 3'd6;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       exec_first;
  logic       ir_indirect;
  logic [2:0] ir_opcode;
  logic       unused_ir_bits;

  assign ir_indirect    = ir_in[IR_W-1];
  assign ir_opcode      = ir_in[IR_W-2:IR_W-4];
  assign unused_ir_bits = ^ir_in[IR_W-5:0];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_T0;
      S_T0:     state_nxt = S_T1;
      S_T1:     state_nxt = S_T2;
`ifdef FETCH_INDIRECT_EN
      S_T2:     state_nxt = ir_indirect ? S_T3 : S_EXEC;
      S_T3:     state_nxt = S_EXEC;
`else
      S_T2:     state_nxt = S_EXEC;
`endif
      S_EXEC:   if (exec_done) state_nxt = halt ? S_HALTED : S_T0;
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // exec_first marks the opening cycle of each EXEC visit so exec_start is a single pulse.
  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= S_IDLE;
      exec_first  <= 1'b0;
      opcode      <= 3'd0;
      indirect    <= 1'b0;
      fetch_count <= 8'd0;
    end else begin
      state      <= state_nxt;
      exec_first <= (state_nxt == S_EXEC) && (state != S_EXEC);
      if (state == S_T2) begin
        opcode      <= ir_opcode;
        indirect    <= ir_indirect;
        fetch_count <= fetch_count + 8'd1;
      end
    end
  end

  always_comb begin
    pc_read    = (state == S_T0);
    pc_inc     = (state == S_T1);
    ir_load    = (state == S_T1);
`ifdef FETCH_INDIRECT_EN
    ar_load    = (state == S_T0) || (state == S_T3);
    mem_read   = (state == S_T1) || (state == S_T3);
`else
    ar_load    = (state == S_T0);
    mem_read   = (state == S_T1);
`endif
    exec_start = (state == S_EXEC) && exec_first;
    busy       = (state != S_IDLE) && (state != S_HALTED);
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter IR_W, default 16: instruction register width; bit IR_W-1 is the indirect bit, bits IR_W-2..IR_W-4 are the opcode.
REQ-002 Port clk  input  1: single clock; all state changes on the rising edge.
REQ-003 Port clear  input  1: reset, synchronous and active-high.
REQ-004 Port start  input  1: begin fetching from IDLE.
REQ-005 Port halt  input  1: stop after the current instruction completes.
REQ-006 Port exec_done  input  1: execute unit has finished the current instruction.
REQ-007 Port ir_in  input  IR_W: current IR contents; valid from the cycle after ir_load.
REQ-008 Port pc_read  output  1: PC drives the bus.
REQ-009 Port pc_inc  output  1: PC increments.
REQ-010 Port ar_load  output  1: AR loads from the bus.
REQ-011 Port mem_read  output  1: memory drives the bus at address AR.
REQ-012 Port ir_load  output  1: IR loads from the bus.
REQ-013 Port exec_start  output  1: one-cycle pulse that hands the instruction to the execute unit.
REQ-014 Port opcode  output  3: latched opcode.
REQ-015 Port indirect  output  1: latched indirect bit.
REQ-016 Port busy  output  1: high in every state except IDLE and HALTED.
REQ-017 Port fetch_count  output  8: number of completed fetches.

Function
REQ-018 States SHALL be IDLE, T0, T1, T2, T3, EXEC and HALTED.
- All strobes are Moore decodes of the state register.
- Strobes are valid for the whole cycle in which the state is held.
REQ-019 IDLE: all strobes low; start=1 -> T0 at the next edge; otherwise remain in IDLE.
REQ-020 T0: pc_read=1, ar_load=1; -> T1 unconditionally.
REQ-021 T1: mem_read=1, ir_load=1, pc_inc=1; -> T2 unconditionally.
REQ-022 T2, no strobes:
- At the edge leaving T2, latch opcode <= ir_in[IR_W-2:IR_W-4] and indirect <= ir_in[IR_W-1].
- Increment fetch_count; 255 wraps to 0.
- Next state is T3 or EXEC per REQ-030/031.
REQ-023 EXEC:
- exec_start=1 only in the first cycle of each EXEC entry.
- Stay in EXEC until exec_done=1; exec_done is accepted in any EXEC cycle, including the first.
REQ-024 On exec_done=1 in EXEC: halt=1 in that cycle -> HALTED; otherwise -> T0.
- No idle cycle between instructions.
REQ-025 HALTED: all strobes low, busy=0; start, exec_done and halt are ignored; exit only via clear.
REQ-026 pc_read and mem_read SHALL never both be high in the same cycle (bus exclusivity).
REQ-027 exec_done outside EXEC, and start outside IDLE, SHALL be ignored.

Reset
REQ-028 clear=1 at any edge SHALL force IDLE, overriding every other input.
- Registers: opcode=0, indirect=0, fetch_count=0.
- Strobes: all low in the following cycle; busy=0.
REQ-029 clear asserted mid-fetch (T0-T3) or mid-EXEC SHALL abandon the instruction with no further pc_inc or exec_start.

Configuration
REQ-030 Macro FETCH_INDIRECT_EN defined:
- T2 with ir_in[IR_W-1]=1 -> T3; T2 with ir_in[IR_W-1]=0 -> EXEC.
- T3 drives mem_read=1, ar_load=1 (AR <= M[AR]) and goes to EXEC.
REQ-031 Macro FETCH_INDIRECT_EN undefined:
- T3 does not exist; T2 always goes to EXEC.
- The indirect output still reports the latched bit.

Verification
REQ-032 clear, then start=1 for one cycle, exec_done tied 1 -> strobe sequence T0(pc_read,ar_load), T1(mem_read,ir_load,pc_inc), T2, EXEC(exec_start); T0 re-entered 4 cycles after the first T0.
REQ-033 ir_in=16'h7800, exec_done after 3 EXEC cycles -> opcode=3'b111, indirect=0, exec_start high exactly 1 cycle, fetch_count=1.
REQ-034 FETCH_INDIRECT_EN defined, ir_in=16'h9123 -> T3 present with mem_read=1 and ar_load=1, then EXEC; indirect=1, opcode=3'b001.
REQ-035 halt=1 with exec_done=1 in EXEC -> HALTED, busy=0; a later start=1 stays in HALTED; clear -> IDLE.
REQ-036 clear during T1 -> next cycle IDLE, all strobes 0, fetch_count=0; 256 consecutive fetches -> fetch_count wraps to 0.
